// File: rtl/traffic_pkg.sv
// Shared light codes, fault codes and monitor state for the traffic lamp safety path.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_INVALID  = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_SKIP     = 3'd3;
  localparam logic [2:0] FLT_SHORT    = 3'd4;
  localparam logic [2:0] FLT_ORDER    = 3'd5;

  typedef enum logic {
    MONITOR     = 1'b0,
    FAULT_FLASH = 1'b1
  } mon_state_t;

  // True when a code is one of the three lit aspects the controller may emit.
  function automatic logic is_valid_light(input logic [2:0] light);
    return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW) || (light == LIGHT_RED);
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Controller-side light codes in, lamp drive and fault status out.
interface traffic_conflict_monitor_if;
  logic [2:0] light_a_in;
  logic [2:0] light_b_in;
  logic       fault_clr;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [2:0] fault_code;

  // Upstream controller / operator side.
  modport master (
    output light_a_in, light_b_in, fault_clr,
    input  lamp_a, lamp_b, fault, fault_code
  );

  // The monitor itself.
  modport slave (
    input  light_a_in, light_b_in, fault_clr,
    output lamp_a, lamp_b, fault, fault_code
  );
endinterface

// File: rtl/light_dir_checker.sv
// Per-direction sequencing checker: remembers last cycle's code and the yellow run length.
module light_dir_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       clr_load,
  output logic       invalid,
  output logic       skip_yellow,
  output logic       short_yellow,
  output logic       illegal_order
);

  localparam int          CW   = $clog2(MIN_YELLOW + 1);
  localparam logic [CW-1:0] YMAX = CW'(MIN_YELLOW);

  logic [2:0]    prev_reg;
  logic [CW-1:0] ycnt_reg;
  logic [CW-1:0] ycnt_next;

  // Yellow run length: saturating count, or preloaded full on a clear so an
  // in-progress yellow phase is treated as already long enough.
  always_comb begin
    ycnt_next = '0;
    if (light == LIGHT_YELLOW) begin
      if (clr_load)
        ycnt_next = YMAX;
      else if (ycnt_reg < YMAX)
        ycnt_next = ycnt_reg + CW'(1);
      else
        ycnt_next = ycnt_reg;
    end
  end

  // Previous code and yellow count track the input every cycle in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= LIGHT_RED;
      ycnt_reg <= '0;
    end else begin
      prev_reg <= light;
      ycnt_reg <= ycnt_next;
    end
  end

  // Violation flags on the current code against last cycle's code.
  always_comb begin
    invalid       = !is_valid_light(light);
    skip_yellow   = (prev_reg == LIGHT_GREEN) && (light == LIGHT_RED);
    short_yellow  = (prev_reg == LIGHT_YELLOW) && (light != LIGHT_YELLOW) && (ycnt_reg < YMAX);
    illegal_order = ((prev_reg == LIGHT_YELLOW) && (light == LIGHT_GREEN)) ||
                    ((prev_reg == LIGHT_RED) && (light == LIGHT_YELLOW));
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage: forwards legal light codes with one cycle latency, latches the first
// violation and flashes red on both directions until an operator clear.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 5,
  parameter int FLASH_HALF = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_conflict_monitor_if.slave   bus
);

  localparam int          FW         = $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_MID  = FW'(FLASH_HALF);

  mon_state_t    state_reg, state_next;
  logic [2:0]    lamp_a_reg, lamp_a_next;
  logic [2:0]    lamp_b_reg, lamp_b_next;
  logic [2:0]    code_reg, code_next;
  logic [FW-1:0] flash_reg, flash_next;

  logic       clr_load;
  logic [1:0] invalid, skip_yellow, short_yellow, illegal_order;
  logic       conflict;
  logic [2:0] viol_code;

  // The clear edge is the only one where checkers preload their yellow counts.
  assign clr_load = (state_reg == FAULT_FLASH) && bus.fault_clr;

  light_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk_a (
    .clk(clk), .rst(rst), .light(bus.light_a_in), .clr_load(clr_load),
    .invalid(invalid[0]), .skip_yellow(skip_yellow[0]),
    .short_yellow(short_yellow[0]), .illegal_order(illegal_order[0])
  );

  light_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk_b (
    .clk(clk), .rst(rst), .light(bus.light_b_in), .clr_load(clr_load),
    .invalid(invalid[1]), .skip_yellow(skip_yellow[1]),
    .short_yellow(short_yellow[1]), .illegal_order(illegal_order[1])
  );

  // Cross-direction conflict and lowest-code-wins priority encode.
  always_comb begin
    conflict  = (bus.light_a_in != LIGHT_RED) && (bus.light_b_in != LIGHT_RED);
    viol_code = FLT_NONE;
    if (|invalid)            viol_code = FLT_INVALID;
    else if (conflict)       viol_code = FLT_CONFLICT;
    else if (|skip_yellow)   viol_code = FLT_SKIP;
    else if (|short_yellow)  viol_code = FLT_SHORT;
    else if (|illegal_order) viol_code = FLT_ORDER;
  end

  // Next state, lamp drive, latched fault code and flash phase.
  always_comb begin
    state_next  = state_reg;
    lamp_a_next = lamp_a_reg;
    lamp_b_next = lamp_b_reg;
    code_next   = code_reg;
    flash_next  = flash_reg;
    case (state_reg)
      MONITOR: begin
        if (viol_code != FLT_NONE) begin
          state_next  = FAULT_FLASH;
          lamp_a_next = LIGHT_RED;
          lamp_b_next = LIGHT_RED;
          code_next   = viol_code;
          flash_next  = '0;
        end else begin
          lamp_a_next = bus.light_a_in;
          lamp_b_next = bus.light_b_in;
        end
      end
      FAULT_FLASH: begin
        if (bus.fault_clr) begin
          state_next  = MONITOR;
          lamp_a_next = bus.light_a_in;
          lamp_b_next = bus.light_b_in;
          code_next   = FLT_NONE;
          flash_next  = '0;
        end else begin
          flash_next  = (flash_reg == FLASH_LAST) ? '0 : flash_reg + FW'(1);
          lamp_a_next = (flash_next < FLASH_MID) ? LIGHT_RED : LIGHT_OFF;
          lamp_b_next = (flash_next < FLASH_MID) ? LIGHT_RED : LIGHT_OFF;
        end
      end
      default: state_next = MONITOR;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= MONITOR;
      lamp_a_reg <= LIGHT_RED;
      lamp_b_reg <= LIGHT_RED;
      code_reg   <= FLT_NONE;
      flash_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      lamp_a_reg <= lamp_a_next;
      lamp_b_reg <= lamp_b_next;
      code_reg   <= code_next;
      flash_reg  <= flash_next;
    end
  end

  assign bus.lamp_a     = lamp_a_reg;
  assign bus.lamp_b     = lamp_b_reg;
  assign bus.fault      = (state_reg == FAULT_FLASH);
  assign bus.fault_code = code_reg;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with hand-computed expectations.
module tb_traffic_conflict_monitor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(.MIN_YELLOW(5), .FLASH_HALF(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                           input logic ef, input logic [2:0] ec);
    check_eq({tag, ".lamp_a"}, {5'd0, bus.lamp_a}, {5'd0, ea});
    check_eq({tag, ".lamp_b"}, {5'd0, bus.lamp_b}, {5'd0, eb});
    check_eq({tag, ".fault"},  {7'd0, bus.fault},  {7'd0, ef});
    check_eq({tag, ".code"},   {5'd0, bus.fault_code}, {5'd0, ec});
  endtask

  // One transaction: drive inputs, take one edge, check outputs 1 time unit later.
  task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b, input logic clr,
                      input logic [2:0] ea, input logic [2:0] eb, input logic ef, input logic [2:0] ec);
    bus.light_a_in = a;
    bus.light_b_in = b;
    bus.fault_clr  = clr;
    @(posedge clk);
    #1;
    $display("%-10s a=%b b=%b clr=%b -> lamp_a=%b lamp_b=%b fault=%b code=%0d",
             tag, a, b, clr, bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code);
    check_all(tag, ea, eb, ef, ec);
  endtask

  // Legal controller cycle: A green, A yellow, B green, B yellow.
  logic [2:0] ph_a [4] = '{G, Y, R, R};
  logic [2:0] ph_b [4] = '{R, R, G, Y};
  int         ph_len [4] = '{6, 5, 6, 5};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.light_a_in = R;
    bus.light_b_in = R;
    bus.fault_clr  = 1'b0;
    #12;
    check_all("reset", R, R, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal operation: lamps follow inputs one cycle later, never faulting.
    for (int loop = 0; loop < 3; loop++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < ph_len[p]; k++)
          step("normal", ph_a[p], ph_b[p], 1'b0, ph_a[p], ph_b[p], 1'b0, 3'd0);
    step("normal", G, R, 1'b0, G, R, 1'b0, 3'd0);

    // Both green: conflict, then flash with an 8-cycle half period.
    step("conflict", G, G, 1'b0, R, R, 1'b1, 3'd2);
    for (int k = 1; k <= 16; k++)
      step("flash", G, G, 1'b0, (k % 16 < 8) ? R : D, (k % 16 < 8) ? R : D, 1'b1, 3'd2);

    // Clear during an A yellow: yellow already counts as complete.
    step("clear_y", Y, R, 1'b1, Y, R, 1'b0, 3'd0);
    step("y_to_r", R, R, 1'b0, R, R, 1'b0, 3'd0);

    // fault_clr in MONITOR does not mask a violation.
    step("mon_clr", G, R, 1'b1, G, R, 1'b0, 3'd0);
    step("mon_clr_c", G, G, 1'b1, R, R, 1'b1, 3'd2);
    // Clear wins over a simultaneous skip-yellow input.
    step("clr_wins", R, R, 1'b1, R, R, 1'b0, 3'd0);
    step("idle", R, R, 1'b0, R, R, 1'b0, 3'd0);

    // Green straight to red.
    step("pre_skip", G, R, 1'b0, G, R, 1'b0, 3'd0);
    step("skip", R, R, 1'b0, R, R, 1'b1, 3'd3);
    step("clear", R, R, 1'b1, R, R, 1'b0, 3'd0);

    // Yellow for only 3 cycles.
    step("pre_short", G, R, 1'b0, G, R, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++)
      step("yel3", Y, R, 1'b0, Y, R, 1'b0, 3'd0);
    step("short", R, R, 1'b0, R, R, 1'b1, 3'd4);
    step("clear", R, R, 1'b1, R, R, 1'b0, 3'd0);

    // Yellow for exactly MIN_YELLOW cycles is fine.
    step("pre_y5", G, R, 1'b0, G, R, 1'b0, 3'd0);
    for (int k = 0; k < 5; k++)
      step("yel5", Y, R, 1'b0, Y, R, 1'b0, 3'd0);
    step("y5_to_r", R, R, 1'b0, R, R, 1'b0, 3'd0);

    // Invalid plus conflict together: invalid wins, later conflict does not overwrite.
    step("invalid", 3'b011, G, 1'b0, R, R, 1'b1, 3'd1);
    step("hold_code", G, G, 1'b0, R, R, 1'b1, 3'd1);
    step("clear", R, R, 1'b1, R, R, 1'b0, 3'd0);

    // Red straight to yellow.
    step("order", Y, R, 1'b0, R, R, 1'b1, 3'd5);

    // Asynchronous reset mid-flash.
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_async", R, R, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", G, R, 1'b0, G, R, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety stage directly downstream of the two-way traffic light controller. It consumes the controller's per-direction light codes and checks them every cycle for illegal or conflicting aspects and for bad sequencing. While the codes are legal it forwards them to the lamp drivers with one cycle of latency. On the first violation it latches a fault code and forces flashing red on both directions until an operator clear.

## Interface
Parameters:
- MIN_YELLOW, 5: minimum consecutive cycles a direction must show yellow before leaving it.
- FLASH_HALF, 8: cycles per half-period of fault flashing.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- light_a_in  input  3  direction A code from the controller: 3'b001 green, 3'b010 yellow, 3'b100 red.
- light_b_in  input  3  direction B code, same encoding.
- fault_clr  input  1  operator clear; only acted on in FAULT_FLASH.
- lamp_a  output  3  direction A lamp drive, same encoding; 3'b000 means dark.
- lamp_b  output  3  direction B lamp drive.
- fault  output  1  high while in FAULT_FLASH.
- fault_code  output  3  first violation since the last clear; 0 means none.

## Operation
States: MONITOR and FAULT_FLASH.

Reset values:
- lamp_a = lamp_b = 3'b100; fault = 0; fault_code = 0.
- State MONITOR.
- prev_a = prev_b = 3'b100.
- Yellow counters = 0; flash counter = 0.

Checks are evaluated only in MONITOR, on the current inputs against prev_* (the inputs registered last cycle). When several checks fire, the lowest code wins:
- 1 INVALID: either input is not one of 001, 010, 100.
- 2 CONFLICT: neither input is red.
- 3 SKIP_YELLOW: a direction goes from prev 001 to current 100.
- 4 SHORT_YELLOW: a direction goes from prev 010 to a non-yellow value while its yellow count < MIN_YELLOW.
- 5 ILLEGAL_ORDER: a direction goes 010→001 or 100→010.

Yellow counter, one per direction:
- Counts consecutive sampled cycles with that input equal to 010, saturating at MIN_YELLOW.
- Cleared on any cycle the input is not yellow.
- Counter width is $clog2(MIN_YELLOW+1).

MONITOR behaviour:
- No violation: lamps are registered copies of the inputs.
- Any violation: at that edge the block enters FAULT_FLASH, sets lamps to 100/100, sets fault = 1, and latches fault_code.

FAULT_FLASH behaviour:
- Flash counter runs 0..2*FLASH_HALF-1 and wraps.
- Lamps are 100/100 for counter < FLASH_HALF, otherwise 000/000.
- Inputs are ignored except for updating prev_*.
- fault_code is held, so a later violation never overwrites it.

Clear from FAULT_FLASH:
- fault_clr high at an edge returns the block to MONITOR.
- At that edge: fault = 0, fault_code = 0, lamps = current inputs, prev_* = current inputs, flash counter = 0.
- Yellow counters are loaded with MIN_YELLOW if the corresponding input is yellow, else 0. A yellow phase already in progress therefore cannot trip SHORT_YELLOW.
- No checks are evaluated in the clear cycle.

prev_* update every cycle in both states.

## Timing
- Input to lamp latency in MONITOR: 1 cycle.
- Violation at edge N: lamps, fault and fault_code all change at edge N. This block adds no extra cycle of exposure.
- Entry into FAULT_FLASH: the first FLASH_HALF cycles are red-on.
- fault_clr together with a violating input in FAULT_FLASH: the clear wins.
- fault_clr in MONITOR: no effect.
- rst mid-flash or mid-yellow: immediate return to reset values. The first post-reset controller output (A green, B red) is legal against prev = red.

## Structure
- Shared package traffic_pkg holds:
  - Light codes LIGHT_GREEN/YELLOW/RED/OFF.
  - Fault code constants FLT_NONE..FLT_ORDER.
  - Monitor state enum.
- Natural sub-module: light_dir_checker, instantiated once per direction.
  - Holds prev, the yellow counter, and the INVALID/SKIP/SHORT/ORDER flags.
  - The top level owns the CONFLICT check, priority encode, state machine and flash counter.

## Test plan
- Drive from the real controller for 300 cycles: lamps equal the inputs delayed 1 cycle; fault stays 0.
- a=001, b=001 at edge N: lamps 100/100, fault=1, code=2 at N; lamps 000/000 at N+8; 100/100 at N+16.
- A goes 001→100 directly: code=3, flashing begins.
- MIN_YELLOW=5, A yellow for 3 cycles then 100: code=4. Yellow for 5 cycles then 100: no fault.
- a=011, b=001 together: code=1, not 2. A later conflict while flashing leaves code=1.
- In FAULT_FLASH, assert fault_clr with a=010, b=100: next edge fault=0, code=0, lamps 010/100. A then goes to 100 on the following cycle with no fault.
